// File: rtl/sequenciador_notas.sv
// Note sequencer and display/tone arbiter: stores an 8-step melody and
// plays it on a tick timebase, or passes live keys through while idle.
//
// Ports:
//   CLK, RST (async, active-high)
//   TECLA_VALIDA/TECLA_NOTA/TECLA_TOM : live keyboard key
//   GRAVA/G_END/G_NOTA/G_TOM/G_DUR    : step memory write port
//   TOCA/PARA/LOOP                    : playback control
//   NOTAS/TOM_module/ATIVO            : note to decoder and tone generator
//   TOCANDO/PASSO                     : playback status and current step
module sequenciador_notas #(
    parameter int TICK_DIV = 50000,
    parameter int DIV_W    = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       TECLA_VALIDA,
    input  logic [2:0] TECLA_NOTA,
    input  logic       TECLA_TOM,
    input  logic       GRAVA,
    input  logic [2:0] G_END,
    input  logic [2:0] G_NOTA,
    input  logic       G_TOM,
    input  logic [3:0] G_DUR,
    input  logic       TOCA,
    input  logic       PARA,
    input  logic       LOOP,
    output logic [2:0] NOTAS,
    output logic       TOM_module,
    output logic       ATIVO,
    output logic       TOCANDO,
    output logic [2:0] PASSO
);

    typedef enum logic [1:0] {
        OCIOSO,
        NOTA,
        PAUSA
    } estado_t;

    estado_t          estado;
    logic [7:0]       mem [8];
    logic [DIV_W-1:0] presc;
    logic [3:0]       ticks;
    logic             tick;
    logic [2:0]       prox;
    logic             seg_ok;
    logic [2:0]       nova;
    logic [7:0]       atual;
    logic [7:0]       carga;
    logic             fim_nota;

    assign tick     = (presc == DIV_W'(TICK_DIV - 1));
    assign prox     = PASSO + 3'd1;
    assign atual    = mem[PASSO];
    // Last tick of the current note's duration
    assign fim_nota = tick && ((ticks + 4'd1) == atual[3:0]);
    // Next step exists only below step 7 and when not an end marker
    assign seg_ok   = (PASSO != 3'd7) && (mem[prox][3:0] != 4'd0);
    assign nova     = seg_ok ? prox : 3'd0;
    assign carga    = mem[nova];

    // Step memory; locked while playing so the running melody is stable
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < 8; i++) begin
                mem[i] <= '0;
            end
        end else if (GRAVA && !TOCANDO) begin
            mem[G_END] <= {G_NOTA, G_TOM, G_DUR};
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            estado     <= OCIOSO;
            presc      <= '0;
            ticks      <= '0;
            NOTAS      <= '0;
            TOM_module <= 1'b0;
            ATIVO      <= 1'b0;
            TOCANDO    <= 1'b0;
            PASSO      <= '0;
        end else if (PARA) begin
            estado  <= OCIOSO;
            presc   <= '0;
            ticks   <= '0;
            ATIVO   <= 1'b0;
            TOCANDO <= 1'b0;
            PASSO   <= '0;
        end else begin
            unique case (estado)
                OCIOSO: begin
                    presc <= '0;
                    ticks <= '0;
                    if (TOCA && (mem[0][3:0] != 4'd0)) begin
                        estado     <= NOTA;
                        NOTAS      <= mem[0][7:5];
                        TOM_module <= mem[0][4];
                        ATIVO      <= 1'b1;
                        TOCANDO    <= 1'b1;
                        PASSO      <= '0;
                    end else begin
                        if (TECLA_VALIDA) begin
                            NOTAS      <= TECLA_NOTA;
                            TOM_module <= TECLA_TOM;
                        end
                        ATIVO <= TECLA_VALIDA;
                    end
                end
                NOTA: begin
                    if (tick) begin
                        presc <= '0;
                        if (fim_nota) begin
                            estado <= PAUSA;
                            ticks  <= '0;
                            ATIVO  <= 1'b0;
                        end else begin
                            ticks <= ticks + 4'd1;
                        end
                    end else begin
                        presc <= presc + DIV_W'(1);
                    end
                end
                PAUSA: begin
                    if (tick) begin
                        presc <= '0;
                        ticks <= '0;
                        if (seg_ok || LOOP) begin
                            estado     <= NOTA;
                            PASSO      <= nova;
                            NOTAS      <= carga[7:5];
                            TOM_module <= carga[4];
                            ATIVO      <= 1'b1;
                        end else begin
                            estado  <= OCIOSO;
                            PASSO   <= '0;
                            TOCANDO <= 1'b0;
                        end
                    end else begin
                        presc <= presc + DIV_W'(1);
                    end
                end
                default: begin
                    estado <= OCIOSO;
                end
            endcase
        end
    end

endmodule

// File: doc/sequenciador_notas.md
# sequenciador_notas

Note sequencer and display/tone arbiter for the keyboard datapath. It stores an 8-step melody of (note, sharp flag, duration) entries and plays it back on a tick timebase. While idle, it passes the live keyboard key through instead. Its NOTAS/TOM_module/ATIVO outputs feed the 7-segment note decoder and the tone generator directly.

## Interface
Parameters:
- TICK_DIV, 50000: clock cycles per duration tick (≥2)
- DIV_W, 16: prescaler width; must hold TICK_DIV-1

Ports:
- CLK  in  1  system clock
- RST  in  1  reset, asynchronous, active-high
- TECLA_VALIDA  in  1  live key pressed
- TECLA_NOTA  in  3  live key note code
- TECLA_TOM  in  1  live key sharp flag
- GRAVA  in  1  write strobe for the step memory (one cycle)
- G_END  in  3  step address to write
- G_NOTA  in  3  note code to store
- G_TOM  in  1  sharp flag to store
- G_DUR  in  4  duration in ticks; 0 = end-of-sequence marker
- TOCA  in  1  start playback pulse
- PARA  in  1  stop pulse
- LOOP  in  1  level; 1 = restart at step 0 after the last step
- NOTAS  out  3  note code to the decoder
- TOM_module  out  1  sharp flag to the decoder
- ATIVO  out  1  note sounding
- TOCANDO  out  1  playback in progress
- PASSO  out  3  current step index

## Operation
- Memory: 8 entries × 8 bits {nota, tom, dur}. Reset clears every entry to 0.
- GRAVA is accepted only when TOCANDO=0. While TOCANDO=1 it is ignored and memory is unchanged.
- States:
  - OCIOSO
  - NOTA: the note sounds
  - PAUSA: one-tick silent gap after each note
- OCIOSO:
  - NOTAS/TOM_module register TECLA_NOTA/TECLA_TOM whenever TECLA_VALIDA=1; otherwise they hold their last value.
  - ATIVO registers TECLA_VALIDA.
  - TOCANDO=0 and PASSO=0.
- OCIOSO → NOTA on TOCA, if mem[0].dur≠0. If mem[0].dur=0, TOCA is ignored.
- On entry to NOTA:
  - NOTAS/TOM_module load mem[PASSO]; ATIVO=1; TOCANDO=1.
  - The prescaler and tick counter clear.
- NOTA → PAUSA after mem[PASSO].dur ticks. ATIVO=0 in PAUSA; NOTAS/TOM_module hold.
- PAUSA exit after 1 tick:
  - If PASSO<7 and mem[PASSO+1].dur≠0: PASSO+1, go to NOTA.
  - Otherwise, the sequence has ended:
    - LOOP=1: PASSO=0, go to NOTA.
    - LOOP=0: go to OCIOSO with PASSO=0 and TOCANDO=0.
- Live keys are ignored while TOCANDO=1. Playback has priority.
- PARA, in any state: next cycle is OCIOSO with ATIVO=0, TOCANDO=0, PASSO=0. NOTAS/TOM_module hold.
- PARA has priority over TOCA when both are asserted in the same cycle. TOCA during playback is ignored; it does not restart.
- LOOP is sampled only at the end-of-sequence decision.

## Timing
- Reset values: NOTAS=0, TOM_module=0, ATIVO=0, TOCANDO=0, PASSO=0. State=OCIOSO, prescaler=0, memory cleared.
- Prescaler counts 0..TICK_DIV-1. The tick fires in the cycle where the count is TICK_DIV-1.
- TOCA sampled high at edge n: outputs show step 0 with ATIVO=1 after edge n.
- A step of duration D:
  - ATIVO=1 for exactly D·TICK_DIV cycles.
  - Then ATIVO=0 for exactly TICK_DIV cycles.
  - The next step's outputs appear on the following edge.
- Live passthrough latency: 1 cycle.
- Memory write: data is visible to a TOCA asserted in the cycle after GRAVA.
- Asynchronous RST mid-playback: all outputs return to reset values immediately; memory is cleared.

## Test plan
- Reset check (TICK_DIV=4 for all tests): assert RST mid-playback → all outputs 0 immediately; TOCA afterwards is ignored because memory is cleared.
- Single step:
  - Setup: write step0={3,1,2}, step1 dur=0; LOOP=0; pulse TOCA.
  - Expected: NOTAS=3, TOM_module=1, ATIVO=1 for 8 cycles; then ATIVO=0 for 4 cycles; then TOCANDO=0, PASSO=0.
- Full sequence with loop:
  - Setup: all 8 steps with dur=1, notes 0..7; LOOP=1.
  - Expected: PASSO steps 0→7, then wraps to 0. Each step gives 4 cycles with ATIVO=1 and 4 with ATIVO=0.
  - Then drop LOOP → stops after step 7.
- Stop during playback:
  - Setup: PARA during NOTA of step 2, with TOCA asserted in the same cycle.
  - Expected: next cycle OCIOSO, ATIVO=0, PASSO=0. No restart.
- Live keys:
  - In OCIOSO, TECLA_VALIDA=1, TECLA_NOTA=5, TECLA_TOM=1 → after 1 cycle NOTAS=5, TOM_module=1, ATIVO=1.
  - The same key during playback → outputs unaffected.
- GRAVA during playback:
  - Action: write step1 dur=0 while step0 plays.
  - Expected: write ignored, step1 still plays. TOCA with mem[0].dur=0 stays in OCIOSO.
